mem_port_arbiter: RTL

- Shares one single-ported unified instruction/data memory between two requesters: the fetch stage (IF) and the load/store stage (DM).
- Fixed-latency memory access, with a request/acknowledge handshake to each requester.
- Data requests win by default because they belong to the older instruction. A starvation counter guarantees fetch progress.
- Sits between the pipeline stages and the memory model. A load/store decoded by the controller raises dm_req; the fetch unit raises if_req every instruction.

---
 rtl/mem_port_arbiter.sv | 138 +++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported unified memory between the
// fetch stage (IF) and the load/store stage (DM). Each grant owns the memory
// for MEM_LAT cycles and completes with a one-cycle ack to its owner.
// DM is preferred because it belongs to the older instruction. A starvation
// counter hands the port to IF after STARVE_MAX consecutive lost arbitrations.
//
// Ports:
//   clk, rst              rising-edge clock, asynchronous active-high reset
//   if_req/if_addr        fetch request (held until if_ack) and its address
//   if_rdata/if_ack       registered fetch data, one-cycle completion pulse
//   dm_req/dm_wen         data request (held until dm_ack), 1 = store
//   dm_addr/dm_wdata      data address and store data
//   dm_rdata/dm_ack       registered load data, one-cycle completion pulse
//   mem_en/mem_wen        memory access active / write enable
//   mem_addr/mem_wdata    latched address and write data during an access
//   mem_rdata             memory read data, valid in the final access cycle
//   busy                  high while an access is in progress
module mem_port_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MEM_LAT    = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              dm_req,
  input  logic              dm_wen,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ack,
  output logic              mem_en,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int unsigned CNT_W = $clog2(MEM_LAT + 1);
  localparam int unsigned ST_W  = $clog2(STARVE_MAX + 1);

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [ST_W-1:0]  starve_cnt;
  logic             owner_dm;

  // DM wins unless IF is waiting and has already lost STARVE_MAX times in a row.
  logic dm_win_c;
  assign dm_win_c = dm_req && !(if_req && (starve_cnt == ST_W'(STARVE_MAX)));

  // Arbitration, access sequencing and completion; mem_addr/mem_wdata/mem_wen
  // double as the latched request registers so requester inputs are ignored
  // once the access has started.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      starve_cnt <= '0;
      owner_dm   <= 1'b0;
      if_rdata   <= '0;
      dm_rdata   <= '0;
      if_ack     <= 1'b0;
      dm_ack     <= 1'b0;
      mem_en     <= 1'b0;
      mem_wen    <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      busy       <= 1'b0;
    end else begin
      if_ack <= 1'b0;
      dm_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (if_req || dm_req) begin
            state  <= ACCESS;
            cnt    <= CNT_W'(MEM_LAT - 1);
            mem_en <= 1'b1;
            busy   <= 1'b1;
            if (dm_win_c) begin
              owner_dm  <= 1'b1;
              mem_addr  <= dm_addr;
              mem_wen   <= dm_wen;
              mem_wdata <= dm_wdata;
              // Only a grant that actually overtakes a waiting fetch counts.
              if (!if_req) begin
                starve_cnt <= '0;
              end else if (starve_cnt != ST_W'(STARVE_MAX)) begin
                starve_cnt <= starve_cnt + ST_W'(1);
              end
            end else begin
              owner_dm   <= 1'b0;
              mem_addr   <= if_addr;
              mem_wen    <= 1'b0;
              starve_cnt <= '0;
            end
          end
        end
        ACCESS: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            // Final access cycle: read data is valid now.
            if (!mem_wen) begin
              if (owner_dm) begin
                dm_rdata <= mem_rdata;
              end else begin
                if_rdata <= mem_rdata;
              end
            end
            if (owner_dm) begin
              dm_ack <= 1'b1;
            end else begin
              if_ack <= 1'b1;
            end
            state   <= IDLE;
            mem_en  <= 1'b0;
            mem_wen <= 1'b0;
            busy    <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
